// File: rtl/hiscore_ram_arbiter.sv
// Hands the shared game-RAM port from the running core to the hiscore engine and back,
// pausing the core at a safe point and holding the mux quiet while it switches.
module hiscore_ram_arbiter #(
  parameter int HS_ADDRESSWIDTH = 10,
  parameter int SETTLE_CYCLES   = 4,
  parameter int SAFE_TIMEOUT    = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hs_req,
  input  logic [HS_ADDRESSWIDTH-1:0] hs_address,
  input  logic [7:0]                 hs_data,
  input  logic                       hs_write,
  output logic                       hs_grant,
  output logic                       hs_abort,
  input  logic [HS_ADDRESSWIDTH-1:0] core_address,
  input  logic [7:0]                 core_data,
  input  logic                       core_write,
  input  logic                       core_safe,
  output logic                       core_pause,
  output logic [HS_ADDRESSWIDTH-1:0] ram_address,
  output logic [7:0]                 ram_data,
  output logic                       ram_we
);

  // state      | meaning
  // IDLE       | core owns the port, not paused
  // PAUSING    | core_pause raised, waiting for core_safe or timeout
  // SETTLE_IN  | mux switched to engine, writes blocked while it settles
  // GRANT      | engine owns the port
  // SETTLE_OUT | mux back on core, writes blocked, core still paused
  typedef enum logic [2:0] {
    IDLE, PAUSING, SETTLE_IN, GRANT, SETTLE_OUT
  } state_t;

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WAIT_LOAD   = 16'(SAFE_TIMEOUT);

  state_t      state, state_n;
  logic        sel_hs, sel_hs_n;
  logic        grant_n, abort_n, pause_n;
  logic        armed, armed_n;
  logic [15:0] wait_cnt, wait_cnt_n;
  logic [7:0]  settle_cnt, settle_cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_hs     <= 1'b0;
      hs_grant   <= 1'b0;
      hs_abort   <= 1'b0;
      core_pause <= 1'b0;
      armed      <= 1'b1;
      wait_cnt   <= 16'd0;
      settle_cnt <= 8'd0;
    end else begin
      state      <= state_n;
      sel_hs     <= sel_hs_n;
      hs_grant   <= grant_n;
      hs_abort   <= abort_n;
      core_pause <= pause_n;
      armed      <= armed_n;
      wait_cnt   <= wait_cnt_n;
      settle_cnt <= settle_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    sel_hs_n     = sel_hs;
    grant_n      = hs_grant;
    abort_n      = 1'b0;
    pause_n      = core_pause;
    wait_cnt_n   = wait_cnt;
    settle_cnt_n = settle_cnt;
    // Re-arming only on a low hs_req forces a retry to be a fresh request edge.
    armed_n      = hs_req ? armed : 1'b1;

    case (state)
      IDLE: begin
        sel_hs_n = 1'b0;
        pause_n  = 1'b0;
        if (hs_req && armed) begin
          state_n    = PAUSING;
          wait_cnt_n = WAIT_LOAD;
          pause_n    = 1'b1;
        end
      end
      PAUSING: begin
        if (!hs_req) begin
          state_n = IDLE;
          pause_n = 1'b0;
        end else if (core_safe) begin
          state_n      = SETTLE_IN;
          sel_hs_n     = 1'b1;
          settle_cnt_n = SETTLE_LOAD;
        end else if (wait_cnt == 16'd0) begin
          state_n = IDLE;
          abort_n = 1'b1;
          pause_n = 1'b0;
          armed_n = 1'b0;
        end else begin
          wait_cnt_n = wait_cnt - 16'd1;
        end
      end
      SETTLE_IN: begin
        if (settle_cnt == 8'd0) begin
          state_n = GRANT;
          grant_n = 1'b1;
        end else begin
          settle_cnt_n = settle_cnt - 8'd1;
        end
      end
      GRANT: begin
        if (!hs_req) begin
          state_n      = SETTLE_OUT;
          grant_n      = 1'b0;
          sel_hs_n     = 1'b0;
          settle_cnt_n = SETTLE_LOAD;
        end
      end
      SETTLE_OUT: begin
        if (settle_cnt == 8'd0) begin
          state_n = IDLE;
          pause_n = 1'b0;
        end else begin
          settle_cnt_n = settle_cnt - 8'd1;
        end
      end
      default: begin
        state_n  = IDLE;
        sel_hs_n = 1'b0;
        grant_n  = 1'b0;
        pause_n  = 1'b0;
      end
    endcase
  end

  assign ram_address = sel_hs ? hs_address : core_address;
  assign ram_data    = sel_hs ? hs_data    : core_data;

  always_comb begin
    ram_we = 1'b0;
    if (state == GRANT)
      ram_we = hs_write;
    else if (state != SETTLE_IN && state != SETTLE_OUT && !sel_hs)
      ram_we = core_write;
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter: grant latency, write gating, hand-back,
// safe-point timeout, mid-grant reset and short request pulses.
module tb_hiscore_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       hs_req, hs_write, core_write, core_safe;
  logic [9:0] hs_address, core_address;
  logic [7:0] hs_data, core_data;
  logic       hs_grant, hs_abort, core_pause, ram_we;
  logic [9:0] ram_address;
  logic [7:0] ram_data;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] CA = 10'h2AA;
  localparam logic [9:0] HA = 10'h123;

  hiscore_ram_arbiter #(
    .HS_ADDRESSWIDTH(10),
    .SETTLE_CYCLES  (4),
    .SAFE_TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hs_req      (hs_req),
    .hs_address  (hs_address),
    .hs_data     (hs_data),
    .hs_write    (hs_write),
    .hs_grant    (hs_grant),
    .hs_abort    (hs_abort),
    .core_address(core_address),
    .core_data   (core_data),
    .core_write  (core_write),
    .core_safe   (core_safe),
    .core_pause  (core_pause),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_we      (ram_we)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; hs_req = 1'b0; hs_write = 1'b0; core_write = 1'b0; core_safe = 1'b0;
    hs_address = HA; hs_data = 8'h5A; core_address = CA; core_data = 8'hC3;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_grant", 16'(hs_grant), 16'h0);
    chk("rst_abort", 16'(hs_abort), 16'h0);
    chk("rst_pause", 16'(core_pause), 16'h0);
    chk("rst_addr", 16'(ram_address), 16'(CA));
    chk("rst_data", 16'(ram_data), 16'hC3);
    core_write = 1'b1; #1;
    chk("idle_core_we", 16'(ram_we), 16'h1);
    core_write = 1'b0;

    // full grant sequence, hs_write held through SETTLE_IN
    core_safe = 1'b1; hs_req = 1'b1; hs_write = 1'b1;
    tick();
    chk("c1_pause", 16'(core_pause), 16'h1);
    chk("c1_addr_core", 16'(ram_address), 16'(CA));
    chk("c1_grant", 16'(hs_grant), 16'h0);
    tick();
    chk("c2_addr_hs", 16'(ram_address), 16'(HA));
    chk("c2_we", 16'(ram_we), 16'h0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk("settle_in_we", 16'(ram_we), 16'h0);
      chk("settle_in_grant", 16'(hs_grant), 16'h0);
    end
    tick();
    chk("c6_grant", 16'(hs_grant), 16'h1);
    hs_write = 1'b0; #1;
    chk("grant_idle_we", 16'(ram_we), 16'h0);

    // single engine write with a competing core write
    core_write = 1'b1; #1;
    chk("grant_core_blocked", 16'(ram_we), 16'h0);
    hs_write = 1'b1; #1;
    chk("grant_we", 16'(ram_we), 16'h1);
    chk("grant_addr", 16'(ram_address), 16'h123);
    chk("grant_data", 16'(ram_data), 16'h5A);
    tick();
    hs_write = 1'b0; #1;
    chk("grant_we_off", 16'(ram_we), 16'h0);

    // hand-back
    hs_req = 1'b0;
    tick();
    chk("t1_grant", 16'(hs_grant), 16'h0);
    chk("t1_addr_core", 16'(ram_address), 16'(CA));
    chk("t1_data_core", 16'(ram_data), 16'hC3);
    chk("t1_we_blocked", 16'(ram_we), 16'h0);
    chk("t1_pause", 16'(core_pause), 16'h1);
    hs_req = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("settle_out_pause", 16'(core_pause), 16'h1);
      chk("settle_out_we", 16'(ram_we), 16'h0);
    end
    hs_req = 1'b0;
    tick();
    chk("t5_pause", 16'(core_pause), 16'h0);
    chk("t5_core_we", 16'(ram_we), 16'h1);
    core_write = 1'b0;
    tick();
    chk("idle_stays", 16'(core_pause), 16'h0);

    // safe-point timeout
    core_safe = 1'b0; hs_req = 1'b1;
    tick();
    chk("to_pause", 16'(core_pause), 16'h1);
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("to_wait_abort", 16'(hs_abort), 16'h0);
      chk("to_wait_pause", 16'(core_pause), 16'h1);
    end
    tick();
    chk("to_abort", 16'(hs_abort), 16'h1);
    chk("to_pause_clr", 16'(core_pause), 16'h0);
    tick();
    chk("to_abort_pulse", 16'(hs_abort), 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_no_retry", 16'(core_pause), 16'h0);
    end
    hs_req = 1'b0;
    tick();
    hs_req = 1'b1;
    tick();
    chk("to_retry", 16'(core_pause), 16'h1);
    hs_req = 1'b0;
    tick();
    chk("to_drop_pause", 16'(core_pause), 16'h0);
    chk("to_drop_abort", 16'(hs_abort), 16'h0);

    // reset while granted
    core_safe = 1'b1; hs_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rg_grant", 16'(hs_grant), 16'h1);
    reset = 1'b1;
    tick();
    chk("rg_grant_clr", 16'(hs_grant), 16'h0);
    chk("rg_pause_clr", 16'(core_pause), 16'h0);
    chk("rg_sel_clr", 16'(ram_address), 16'(CA));
    reset = 1'b0;
    tick();
    chk("rg_restart", 16'(core_pause), 16'h1);
    chk("rg_restart_addr", 16'(ram_address), 16'(CA));
    hs_req = 1'b0;
    tick();
    chk("rg_drop", 16'(core_pause), 16'h0);

    // short request pulse without a safe point
    core_safe = 1'b0; hs_req = 1'b1;
    tick();
    chk("pl_pause1", 16'(core_pause), 16'h1);
    tick();
    chk("pl_pause2", 16'(core_pause), 16'h1);
    hs_req = 1'b0;
    tick();
    chk("pl_idle", 16'(core_pause), 16'h0);
    chk("pl_no_abort", 16'(hs_abort), 16'h0);
    tick();
    chk("pl_no_abort2", 16'(hs_abort), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
